// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit add/subtract computed one nibble per clock through a 4-bit CLA slice
// Operands are accepted on an in_valid/in_ready handshake and the result is released on out_valid/out_ready.

module carry_look_ahead_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       C_out
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g = A & B;
    p = A ^ B;
    c[0]  = Cin;
    c[1]  = g[0] | (p[0] & Cin);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
    C_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & Cin);
    S = p ^ c;
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [3:0]       cla_a, cla_b, cla_s;
  logic             cla_co;

  // Nibble mux feeding the single CLA slice
  always_comb begin
    cla_a = '0;
    cla_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cla_a = a_q[4*i +: 4];
        cla_b = b_q[4*i +: 4];
      end
    end
  end

  carry_look_ahead_adder u_cla (
    .A     (cla_a),
    .B     (cla_b),
    .Cin   (carry_q),
    .S     (cla_s),
    .C_out (cla_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[4*i +: 4] = cla_s;
        end
        carry_d = cla_co;
        if (idx_q == LAST_IDX) begin
          cout_d  = cla_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (sum_d == '0);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed and randomized checks of nibble_serial_adder against an arithmetic model

module tb_nibble_serial_adder;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout, ovf, zero;

  int n_total = 0;
  int n_pass  = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Plain integer arithmetic reference
  function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                                input logic ts, output logic [W-1:0] es, output logic eco,
                                output logic eov, output logic ez);
    longint ua, ub, sa, sb, r, sr;
    ua = longint'(ta);
    ub = longint'(tb_v);
    sa = longint'($signed(ta));
    sb = longint'($signed(tb_v));
    if (ts) begin
      r   = ua - ub;
      eco = (ua >= ub);
      sr  = sa - sb;
    end else begin
      r   = ua + ub + longint'(tc);
      eco = (r >= 65536);
      sr  = sa + sb + longint'(tc);
    end
    es  = W'(r);
    eov = (sr > 32767) || (sr < -32768);
    ez  = (es == '0);
  endfunction

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input logic ts);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tc, input logic ts, input int hold);
    int n;
    logic [W-1:0] es;
    logic eco, eov, ez;
    model(ta, tb_v, tc, ts, es, eco, eov, ez);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(NIB));
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(eco));
    check({tag, "_ovf"}, 32'(ovf), 32'(eov));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input logic ts);
    start_op(ta, tb_v, tc, ts);
    finish_op(tag, ta, tb_v, tc, ts, 0);
  endtask

  initial begin
    logic [W-1:0] hs;
    logic hc, ho, hz;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("plain_add", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
    do_op("cin_add", 16'h0001, 16'h0001, 1'b1, 1'b0);
    do_op("sub_cin_ignored", 16'h0010, 16'h0010, 1'b1, 1'b1);
    check("const_sum_2233", 32'(16'h1234 + 16'h0FFF), 32'h2233);

    // Backpressure: DONE must hold while inputs churn
    start_op(16'h4321, 16'h1111, 1'b0, 1'b0);
    repeat (NIB) begin
      @(posedge clk); #1;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    hs = sum; hc = cout; ho = ovf; hz = zero;
    check("bp_sum_value", 32'(hs), 32'h5432);
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      check("bp_hold", {12'd0, sum, cout, ovf, zero, in_ready, out_valid},
            {12'd0, hs, hc, ho, hz, 1'b0, 1'b1});
    end
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_after_release", {30'd0, in_ready, out_valid}, 32'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_accepted", 32'(in_ready), 32'd0);
    finish_op("bp_next", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 2);

    // Asynchronous reset in the middle of RUN
    start_op(16'hABCD, 16'h1111, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_sum", 32'(sum), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      start_op(ra, rb, rc, rs);
      finish_op("rand", ra, rb, rc, rs, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
